// File: rtl/ipsl_pcie_apb_pkg.sv
// rtl/ipsl_pcie_apb_pkg.sv - shared state encodings and APB widths for the PCIe APB master
package ipsl_pcie_apb_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_GAP    = 2'd3
    } apb_state_t;

endpackage

// File: rtl/ipsl_pcie_apb_cnt.sv
// rtl/ipsl_pcie_apb_cnt.sv - loadable down-counter with zero flag, saturating at 0
module ipsl_pcie_apb_cnt #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic [W-1:0] o_count,
    output logic         o_zero
);

    logic [W-1:0] cnt;

    // load has priority so a new interval can start on the same edge the old one ends
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (i_load) begin
            cnt <= i_load_val;
        end else if (i_dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign o_count = cnt;
    assign o_zero  = (cnt == '0);

endmodule

// File: rtl/ipsl_pcie_apb_mst.sv
// rtl/ipsl_pcie_apb_mst.sv - command-stream APB master feeding the PCIe APB crossing; optional IPSL_PCIE_APB_MST_TIMEOUT_EN
module ipsl_pcie_apb_mst
    import ipsl_pcie_apb_pkg::*;
#(
    parameter int GAP_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_we,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [DATA_W-1:0] i_cmd_wdata,
    input  logic [STRB_W-1:0] i_cmd_strb,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err,
    output logic              o_busy,
    output logic              o_p_sel,
    output logic              o_p_ce,
    output logic              o_p_we,
    output logic [ADDR_W-1:0] o_p_addr,
    output logic [DATA_W-1:0] o_p_wdata,
    output logic [STRB_W-1:0] o_p_strb,
    input  logic              i_p_rdy,
    input  logic [DATA_W-1:0] i_p_rdata
);

    localparam int GAP_W = 8;
    localparam int TO_W  = 16;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
    localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT_CYCLES - 1);

    apb_state_t        state, state_nxt;
    logic              accept;
    logic              done;
    logic              abort;
    logic              gap_load;
    logic              gap_dec;
    logic              gap_zero;
    logic              to_expired;
    logic              sel_d;
    logic              ce_d;
    logic [DATA_W-1:0] rdata_d;
    logic [GAP_W-1:0]  unused_gap_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        gap_load  = 1'b0;
        gap_dec   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                // completion beats an expiry landing on the same cycle
                if (i_p_rdy) begin
                    done      = 1'b1;
                    gap_load  = 1'b1;
                    state_nxt = ST_GAP;
                end else if (to_expired) begin
                    abort     = 1'b1;
                    gap_load  = 1'b1;
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_zero) begin
                    state_nxt = ST_IDLE;
                end else begin
                    gap_dec = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        sel_d   = (state_nxt == ST_SETUP) || (state_nxt == ST_ACCESS);
        ce_d    = (state_nxt == ST_ACCESS);
        rdata_d = (done && !o_p_we) ? i_p_rdata : '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_p_sel     <= 1'b0;
            o_p_ce      <= 1'b0;
            o_p_we      <= 1'b0;
            o_p_addr    <= '0;
            o_p_wdata   <= '0;
            o_p_strb    <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= '0;
        end else begin
            o_p_sel     <= sel_d;
            o_p_ce      <= ce_d;
            o_rsp_valid <= done || abort;
            o_rsp_rdata <= rdata_d;
            if (accept) begin
                o_p_we    <= i_cmd_we;
                o_p_addr  <= i_cmd_addr;
                o_p_wdata <= i_cmd_wdata;
                o_p_strb  <= i_cmd_strb;
            end
        end
    end

    // GAP holds for GAP_CYCLES+1 cycles so the next sel rises GAP_CYCLES+2 after the fall
    ipsl_pcie_apb_cnt #(.W(GAP_W)) u_gap_cnt (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (gap_load),
        .i_load_val (GAP_LOAD),
        .i_dec      (gap_dec),
        .o_count    (unused_gap_cnt),
        .o_zero     (gap_zero)
    );

`ifdef IPSL_PCIE_APB_MST_TIMEOUT_EN
    logic            to_zero;
    logic [TO_W-1:0] unused_to_cnt;

    // loaded with N-1 at accept so sel stays high for exactly N cycles on expiry
    ipsl_pcie_apb_cnt #(.W(TO_W)) u_to_cnt (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (accept),
        .i_load_val (TO_LOAD),
        .i_dec      ((state == ST_SETUP) || (state == ST_ACCESS)),
        .o_count    (unused_to_cnt),
        .o_zero     (to_zero)
    );

    assign to_expired = to_zero && (state == ST_ACCESS);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rsp_err <= 1'b0;
        end else begin
            o_rsp_err <= abort;
        end
    end
`else
    logic unused_to_cfg;

    assign unused_to_cfg = ^TO_LOAD;
    assign to_expired    = 1'b0;
    assign o_rsp_err     = 1'b0;
`endif

    assign o_cmd_ready = (state == ST_IDLE);
    assign o_busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_ipsl_pcie_apb_mst.sv
// tb/tb_ipsl_pcie_apb_mst.sv - directed bench for ipsl_pcie_apb_mst; IPSL_PCIE_APB_MST_TIMEOUT_EN selects timeout steps
module tb_ipsl_pcie_apb_mst;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic        i_cmd_we;
    logic [15:0] i_cmd_addr;
    logic [31:0] i_cmd_wdata;
    logic [3:0]  i_cmd_strb;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic        o_busy;
    logic        o_p_sel;
    logic        o_p_ce;
    logic        o_p_we;
    logic [15:0] o_p_addr;
    logic [31:0] o_p_wdata;
    logic [3:0]  o_p_strb;
    logic        i_p_rdy;
    logic [31:0] i_p_rdata;

    int total = 0;
    int bad   = 0;

    ipsl_pcie_apb_mst #(.GAP_CYCLES(8), .TIMEOUT_CYCLES(16)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_cmd_we    (i_cmd_we),
        .i_cmd_addr  (i_cmd_addr),
        .i_cmd_wdata (i_cmd_wdata),
        .i_cmd_strb  (i_cmd_strb),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_rdata (o_rsp_rdata),
        .o_rsp_err   (o_rsp_err),
        .o_busy      (o_busy),
        .o_p_sel     (o_p_sel),
        .o_p_ce      (o_p_ce),
        .o_p_we      (o_p_we),
        .o_p_addr    (o_p_addr),
        .o_p_wdata   (o_p_wdata),
        .o_p_strb    (o_p_strb),
        .i_p_rdy     (i_p_rdy),
        .i_p_rdata   (i_p_rdata)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 40 && !o_cmd_ready; n++) tick();
        chk("back_to_idle", o_cmd_ready, 1);
    endtask

    task automatic issue(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb);
        i_cmd_valid = 1'b1;
        i_cmd_we    = we;
        i_cmd_addr  = addr;
        i_cmd_wdata = wdata;
        i_cmd_strb  = strb;
        tick();
        i_cmd_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rise;
        int drop;
        i_rst_n     = 1'b0;
        i_cmd_valid = 1'b0;
        i_cmd_we    = 1'b0;
        i_cmd_addr  = '0;
        i_cmd_wdata = '0;
        i_cmd_strb  = '0;
        i_p_rdy     = 1'b0;
        i_p_rdata   = '0;
        repeat (2) tick();

        chk("rst_ready", o_cmd_ready, 1);
        chk("rst_sel", o_p_sel, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_rsp_valid", o_rsp_valid, 0);
        chk("rst_addr", o_p_addr, 0);
        chk("rst_err", o_rsp_err, 0);
        i_rst_n = 1'b1;
        tick();

        // 1: write, rdy after 3 ACCESS cycles
        issue(1'b1, 16'h0010, 32'h1234_5678, 4'hF);
        chk("w_sel_at_accept1", o_p_sel, 1);
        chk("w_ce_low_setup", o_p_ce, 0);
        chk("w_ready_low", o_cmd_ready, 0);
        chk("w_busy", o_busy, 1);
        chk("w_addr", o_p_addr, 32'h0010);
        chk("w_wdata", o_p_wdata, 32'h1234_5678);
        chk("w_strb", o_p_strb, 4'hF);
        chk("w_we", o_p_we, 1);
        tick();
        chk("w_ce_at_accept2", o_p_ce, 1);
        chk("w_sel_access", o_p_sel, 1);
        tick();
        tick();
        chk("w_addr_stable", o_p_addr, 32'h0010);
        chk("w_wdata_stable", o_p_wdata, 32'h1234_5678);
        i_p_rdy   = 1'b1;
        i_p_rdata = 32'hFFFF_FFFF;
        tick();
        i_p_rdy = 1'b0;
        chk("w_rsp_valid", o_rsp_valid, 1);
        chk("w_rsp_err", o_rsp_err, 0);
        chk("w_rsp_rdata_zero", o_rsp_rdata, 0);
        chk("w_sel_drop", o_p_sel, 0);
        chk("w_ce_drop", o_p_ce, 0);
        tick();
        chk("w_rsp_one_cycle", o_rsp_valid, 0);
        wait_idle();

        // 2: read returns data for exactly one cycle
        issue(1'b0, 16'h0004, 32'h0, 4'h0);
        tick();
        i_p_rdy   = 1'b1;
        i_p_rdata = 32'hA5A5_5A5A;
        tick();
        i_p_rdy   = 1'b0;
        i_p_rdata = 32'h1111_2222;
        chk("r_rsp_valid", o_rsp_valid, 1);
        chk("r_rsp_rdata", o_rsp_rdata, 32'hA5A5_5A5A);
        tick();
        chk("r_rsp_valid_low", o_rsp_valid, 0);
        chk("r_rdata_cleared", o_rsp_rdata, 0);
        wait_idle();

        // 3: back-to-back with valid held, GAP_CYCLES=8
        i_cmd_valid = 1'b1;
        i_cmd_we    = 1'b1;
        i_cmd_addr  = 16'h0020;
        i_cmd_wdata = 32'h1;
        i_cmd_strb  = 4'h3;
        tick();
        chk("b2b_sel1", o_p_sel, 1);
        i_cmd_addr  = 16'h0024;
        i_cmd_wdata = 32'h2;
        tick();
        i_p_rdy = 1'b1;
        tick();
        i_p_rdy = 1'b0;
        chk("b2b_sel_fall", o_p_sel, 0);
        chk("b2b_ready_gap0", o_cmd_ready, 0);
        rise = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (n == 5) chk("b2b_ready_gap5", o_cmd_ready, 0);
            if (n == 9) chk("b2b_ready_idle9", o_cmd_ready, 1);
            if (o_p_sel) begin
                rise = n;
                break;
            end
        end
        i_cmd_valid = 1'b0;
        chk("b2b_rise_delay", rise, 10);
        chk("b2b_addr2", o_p_addr, 32'h0024);
        chk("b2b_wdata2", o_p_wdata, 32'h2);
        tick();
        i_p_rdy = 1'b1;
        tick();
        i_p_rdy = 1'b0;
        chk("b2b_rsp2", o_rsp_valid, 1);
        wait_idle();

        // 4: asynchronous reset in ACCESS, then stray rdy
        issue(1'b1, 16'h0030, 32'hCAFE_0000, 4'h1);
        tick();
        chk("rst4_ce_before", o_p_ce, 1);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("rst4_sel", o_p_sel, 0);
        chk("rst4_ce", o_p_ce, 0);
        chk("rst4_busy", o_busy, 0);
        chk("rst4_ready", o_cmd_ready, 1);
        chk("rst4_addr", o_p_addr, 0);
        chk("rst4_rsp", o_rsp_valid, 0);
        tick();
        i_rst_n   = 1'b1;
        i_p_rdy   = 1'b1;
        i_p_rdata = 32'h55;
        tick();
        i_p_rdy = 1'b0;
        chk("stray_rsp", o_rsp_valid, 0);
        chk("stray_sel", o_p_sel, 0);
        chk("stray_ready", o_cmd_ready, 1);

`ifdef IPSL_PCIE_APB_MST_TIMEOUT_EN
        // 5: timeout after 16 cycles of sel, late rdy ignored
        issue(1'b1, 16'h0040, 32'h9, 4'hF);
        drop = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (!o_p_sel) begin
                drop = n;
                break;
            end
        end
        chk("to_drop_cycle", drop, 16);
        chk("to_rsp_valid", o_rsp_valid, 1);
        chk("to_rsp_err", o_rsp_err, 1);
        chk("to_rsp_rdata", o_rsp_rdata, 0);
        i_p_rdy   = 1'b1;
        i_p_rdata = 32'h77;
        tick();
        i_p_rdy = 1'b0;
        chk("to_late_rsp", o_rsp_valid, 0);
        chk("to_err_cleared", o_rsp_err, 0);
        wait_idle();

        // 6: rdy on the expiry cycle wins
        issue(1'b0, 16'h0044, 32'h0, 4'h0);
        repeat (15) tick();
        chk("tie_sel_high", o_p_sel, 1);
        i_p_rdy   = 1'b1;
        i_p_rdata = 32'h0BAD_F00D;
        tick();
        i_p_rdy = 1'b0;
        chk("tie_rsp_valid", o_rsp_valid, 1);
        chk("tie_rsp_err", o_rsp_err, 0);
        chk("tie_rsp_rdata", o_rsp_rdata, 32'h0BAD_F00D);
        wait_idle();
`else
        // 5: without timeout, ACCESS waits indefinitely
        issue(1'b1, 16'h0040, 32'h9, 4'hF);
        repeat (100) tick();
        chk("nto_sel_high", o_p_sel, 1);
        chk("nto_ce_high", o_p_ce, 1);
        chk("nto_no_rsp", o_rsp_valid, 0);
        i_p_rdy = 1'b1;
        tick();
        i_p_rdy = 1'b0;
        chk("nto_rsp_valid", o_rsp_valid, 1);
        chk("nto_rsp_err", o_rsp_err, 0);
        wait_idle();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
